// File: rtl/spi_lcd_streamer.sv
// SPI transmit engine for PCD8544-class LCDs: buffers {dc, data} words in a FIFO,
// drives the LCD reset pulse, then streams frames with a runtime clock divider.
module spi_lcd_streamer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter int RST_CYCLES = 1000
) (
    input  logic                        clock,
    input  logic                        Reset,
    input  logic                        wr_en,
    input  logic                        wr_dc,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        flush,
    input  logic [DIV_W-1:0]            div_factor,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow,
    output logic                        ready,
    output logic                        busy,
    output logic                        done,
    output logic                        mosi,
    output logic                        sclk,
    output logic                        sce,
    output logic                        dc,
    output logic                        rst
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int IW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     init_cnt_q, init_cnt_d;
    logic [DIV_W-1:0]  h_q, h_d, h_cnt_q, h_cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              phase_q, phase_d;  // 0 = leading half, 1 = trailing half
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              mosi_d, sclk_d, sce_d, dc_d, rst_d, ready_d, busy_d, done_d;

    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level_d;
    logic              full_d, overflow_d;
    logic [DATA_W:0]   head;
    logic              push_ok, pop, seg_end, last_bit, init_done;
    logic              start_shift, lead_step, bit_step;

    assign head        = mem[rd_ptr];
    assign push_ok     = wr_en && !full && !flush;
    assign pop         = (state_q == S_IDLE) && (level != '0);
    assign seg_end     = (h_cnt_q == h_q - DIV_W'(1));
    assign last_bit    = (bit_q == BW'(DATA_W - 1));
    assign init_done   = (init_cnt_q == IW'(RST_CYCLES - 1));
    assign start_shift = (state_q == S_SETUP) && seg_end;
    // lead_step: entering a trailing half; bit_step: entering the next bit's leading half
    assign lead_step   = (state_q == S_SHIFT) && seg_end && !phase_q && !last_bit;
    assign bit_step    = (state_q == S_SHIFT) && seg_end && phase_q && !last_bit;

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            h_q        <= DIV_W'(1);
            h_cnt_q    <= '0;
            bit_q      <= '0;
            phase_q    <= 1'b0;
            sreg_q     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            full       <= 1'b0;
            overflow   <= 1'b0;
            mosi       <= 1'b0;
            sclk       <= CPOL;
            sce        <= 1'b1;
            dc         <= 1'b0;
            rst        <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register sees pre-edge values.
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            h_q        <= h_d;
            h_cnt_q    <= h_cnt_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            sreg_q     <= sreg_d;
            level      <= level_d;
            full       <= full_d;
            overflow   <= overflow_d;
            mosi       <= mosi_d;
            sclk       <= sclk_d;
            sce        <= sce_d;
            dc         <= dc_d;
            rst        <= rst_d;
            ready      <= ready_d;
            busy       <= busy_d;
            done       <= done_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // NOTE: storage has no reset; level and the pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= {wr_dc, wr_data};
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            S_INIT:  if (init_done) state_d = S_IDLE;
            S_IDLE:  if (level != '0) state_d = S_LOAD;
            S_LOAD:  state_d = S_SETUP;
            S_SETUP: if (seg_end) state_d = S_SHIFT;
            S_SHIFT: if (seg_end && phase_q && last_bit) state_d = S_HOLD;
            S_HOLD:  if (seg_end) state_d = S_GAP;
            S_GAP:   if (seg_end) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Outputs are registered from next-state values so pins change with the state.
    always_comb begin : output_next
        // NOTE: every target gets a default first, so no latches are inferred.
        init_cnt_d = (state_q == S_INIT && !init_done) ? init_cnt_q + IW'(1) : init_cnt_q;
        h_cnt_d    = '0;
        if ((state_q inside {S_SETUP, S_SHIFT, S_HOLD, S_GAP}) && !seg_end)
            h_cnt_d = h_cnt_q + DIV_W'(1);
        h_d     = h_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        sreg_d  = sreg_q;
        mosi_d  = mosi;
        dc_d    = dc;
        if (pop) begin
            h_d     = (div_factor == '0) ? DIV_W'(1) : div_factor;
            sreg_d  = head[DATA_W-1:0];
            dc_d    = head[DATA_W];
            bit_d   = '0;
            phase_d = 1'b0;
            if (!CPHA) mosi_d = head[DATA_W-1];
        end
        if (state_q == S_SHIFT && seg_end) phase_d = !phase_q;
        if (bit_step) bit_d = bit_q + BW'(1);
        if (CPHA) begin
            if (start_shift || bit_step) begin
                mosi_d = sreg_q[DATA_W-1];
                sreg_d = sreg_q << 1;
            end
        end else if (lead_step) begin
            mosi_d = sreg_q[DATA_W-2];
            sreg_d = sreg_q << 1;
        end

        level_d    = flush ? '0 : level + LW'(push_ok) - LW'(pop);
        full_d     = (level_d == LW'(FIFO_DEPTH));
        overflow_d = flush ? 1'b0 : (overflow || (wr_en && full));

        sce_d   = !(state_d inside {S_LOAD, S_SETUP, S_SHIFT, S_HOLD});
        sclk_d  = (state_d == S_SHIFT && !phase_d) ? !CPOL : CPOL;
        done_d  = (state_q == S_HOLD) && (state_d == S_GAP);
        rst_d   = (state_d != S_INIT);
        ready_d = (state_d != S_INIT);
        busy_d  = !(state_d inside {S_IDLE, S_INIT}) || (level_d != '0);
    end

endmodule

// File: tb/tb_spi_lcd_streamer.sv
// Directed bench: one instance in mode 0 with a 4-entry FIFO, one in mode 3;
// a monitor records each frame (start cycle, sce-low length, sampled bits, dc).
module tb_spi_lcd_streamer;

    logic clock = 1'b0;
    logic Reset = 1'b0;
    always #5 clock = ~clock;

    logic        wr_en_a = 0, wr_dc_a = 0, flush_a = 0;
    logic [7:0]  wr_data_a = '0;
    logic [15:0] div_a = 16'd1;
    logic        full_a, overflow_a, ready_a, busy_a, done_a, mosi_a, sclk_a, sce_a, dc_a, rst_a;
    logic [2:0]  level_a;

    logic        wr_en_b = 0, wr_dc_b = 0, flush_b = 0;
    logic [7:0]  wr_data_b = '0;
    logic [15:0] div_b = 16'd0;
    logic        full_b, overflow_b, ready_b, busy_b, done_b, mosi_b, sclk_b, sce_b, dc_b, rst_b;
    logic [4:0]  level_b;

    spi_lcd_streamer #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16), .CPOL(1'b0), .CPHA(1'b0),
                       .RST_CYCLES(1000)) u_dut_a (
        .clock(clock), .Reset(Reset), .wr_en(wr_en_a), .wr_dc(wr_dc_a), .wr_data(wr_data_a),
        .flush(flush_a), .div_factor(div_a), .full(full_a), .level(level_a),
        .overflow(overflow_a), .ready(ready_a), .busy(busy_a), .done(done_a),
        .mosi(mosi_a), .sclk(sclk_a), .sce(sce_a), .dc(dc_a), .rst(rst_a));

    spi_lcd_streamer #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16), .CPOL(1'b1), .CPHA(1'b1),
                       .RST_CYCLES(1000)) u_dut_b (
        .clock(clock), .Reset(Reset), .wr_en(wr_en_b), .wr_dc(wr_dc_b), .wr_data(wr_data_b),
        .flush(flush_b), .div_factor(div_b), .full(full_b), .level(level_b),
        .overflow(overflow_b), .ready(ready_b), .busy(busy_b), .done(done_b),
        .mosi(mosi_b), .sclk(sclk_b), .sce(sce_b), .dc(dc_b), .rst(rst_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- frame monitor (index 0 = dut a, 1 = dut b) ----------------
    logic [1:0] sce_w, sclk_w, mosi_w, dc_w, done_w;
    assign sce_w  = {sce_b, sce_a};
    assign sclk_w = {sclk_b, sclk_a};
    assign mosi_w = {mosi_b, mosi_a};
    assign dc_w   = {dc_b, dc_a};
    assign done_w = {done_b, done_a};

    int         cyc = 0;
    logic [1:0] p_sce = 2'b11, p_sclk = 2'b10, p_mosi = 2'b00;
    logic [7:0] cur_bits [2];
    int         cur_len [2], cur_nb [2], cur_start [2];
    logic       cur_dc [2];
    logic [7:0] f_bits [2][16];
    int         f_len [2][16], f_nb [2][16], f_start [2][16];
    logic       f_dc [2][16], f_done [2][16];
    int         nfr [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    int         mosi_bad [2] = '{0, 0};

    always @(posedge clock) begin
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (Reset) begin
                if (p_sce[d] && !sce_w[d]) begin
                    cur_len[d] = 0; cur_nb[d] = 0; cur_bits[d] = '0;
                    cur_start[d] = cyc; cur_dc[d] = dc_w[d];
                end
                if (!sce_w[d]) begin
                    cur_len[d]++;
                    if (!p_sclk[d] && sclk_w[d]) begin
                        cur_bits[d] = {cur_bits[d][6:0], mosi_w[d]};
                        cur_nb[d]++;
                    end
                end
                // in both modes mosi may only move when sclk falls inside a frame
                if (!p_sce[d] && !sce_w[d] && mosi_w[d] != p_mosi[d] && !(p_sclk[d] && !sclk_w[d]))
                    mosi_bad[d]++;
                if (!p_sce[d] && sce_w[d]) begin
                    if (nfr[d] < 16) begin
                        f_bits[d][nfr[d]]  = cur_bits[d];
                        f_len[d][nfr[d]]   = cur_len[d];
                        f_nb[d][nfr[d]]    = cur_nb[d];
                        f_start[d][nfr[d]] = cur_start[d];
                        f_dc[d][nfr[d]]    = cur_dc[d];
                        f_done[d][nfr[d]]  = done_w[d];
                    end
                    nfr[d]++;
                end
                if (done_w[d]) done_cnt[d]++;
            end
            p_sce[d]  = sce_w[d];
            p_sclk[d] = sclk_w[d];
            p_mosi[d] = mosi_w[d];
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_frames(input int d, input int target, input int budget, input string tag);
        int n = 0;
        while (nfr[d] < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(nfr[d] >= target), 32'd1);
    endtask

    task automatic check_frame(input int d, input int i, input logic [7:0] bits,
                               input logic dcv, input int len);
        check($sformatf("f%0d_%0d_bits", d, i), f_bits[d][i], bits);
        check($sformatf("f%0d_%0d_nbits", d, i), f_nb[d][i], 8);
        check($sformatf("f%0d_%0d_dc", d, i), f_dc[d][i], dcv);
        check($sformatf("f%0d_%0d_sce_len", d, i), f_len[d][i], len);
        check($sformatf("f%0d_%0d_done_at_end", d, i), f_done[d][i], 1);
    endtask

    task automatic push_a(input logic [8:0] w);
        wr_en_a = 1'b1;
        {wr_dc_a, wr_data_a} = w;
        step();
        wr_en_a = 1'b0;
    endtask

    task automatic measure_init(input string tag);
        int cnt = 0;
        int bad = 0;
        while (cnt < 1100) begin
            step();
            cnt++;
            if (sce_a !== 1'b1 || sclk_a !== 1'b0) bad++;
            if (rst_a) break;
        end
        check({tag, "_rst_low_cycles"}, cnt, 1000);
        check({tag, "_idle_pins"}, bad, 0);
        check({tag, "_ready"}, ready_a, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [8:0] init_words [6] = '{9'h011, 9'h122, 9'h033, 9'h144, 9'h155, 9'h066};
    logic [8:0] three_words [3] = '{9'h00F, 9'h1F0, 9'h081};

    initial begin
        int k, r, cnt, bad, n;

        // reset state
        repeat (3) step();
        check("rst_sce", sce_a, 1);
        check("rst_sclk", sclk_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_dc", dc_a, 0);
        check("rst_rst", rst_a, 0);
        check("rst_ready", ready_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_full", full_a, 0);
        check("rst_level", level_a, 0);
        check("rst_overflow", overflow_a, 0);
        check("rst_sclk_b_idle_high", sclk_b, 1);

        // INIT: pushes held, overflow on the 5th and 6th, rst pulse length
        Reset = 1'b1;
        cnt = 0;
        bad = 0;
        while (cnt < 1100) begin
            if (cnt < 6) begin
                wr_en_a = 1'b1;
                {wr_dc_a, wr_data_a} = init_words[cnt];
            end else begin
                wr_en_a = 1'b0;
            end
            step();
            cnt++;
            if (sce_a !== 1'b1 || sclk_a !== 1'b0) bad++;
            if (cnt == 7) begin
                check("init_level", level_a, 4);
                check("init_full", full_a, 1);
                check("init_overflow", overflow_a, 1);
                check("init_busy", busy_a, 1);
                check("init_ready_low", ready_a, 0);
            end
            if (rst_a) break;
        end
        check("init_rst_low_cycles", cnt, 1000);
        check("init_idle_pins", bad, 0);
        check("init_ready", ready_a, 1);
        r = cyc;

        // the four held words go out at H=1, spaced 1 + 19 + 1 = 21 cycles
        wait_frames(0, 4, 200, "init_frames");
        check("init_first_start", f_start[0][0], r + 1);
        for (int i = 0; i < 4; i++)
            check_frame(0, i, init_words[i][7:0], init_words[i][8], 19);
        for (int i = 0; i < 3; i++)
            check($sformatf("init_spacing_%0d", i), f_start[0][i+1] - f_start[0][i], 21);
        check("init_done_count", done_cnt[0], 4);
        check("overflow_sticky", overflow_a, 1);
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        check("flush_clears_overflow", overflow_a, 0);
        check("flush_full", full_a, 0);

        // single 0xA5 data word at H=4: sce low 1 + 18*4 = 73
        div_a = 16'd4;
        k = cyc;
        push_a(9'h1A5);
        wait_frames(0, 5, 300, "a5_frame");
        check("a5_start", f_start[0][4], k + 2);
        check_frame(0, 4, 8'hA5, 1'b1, 73);
        check("a5_mosi_holds_lsb", mosi_a, 1);
        repeat (6) step();
        check("a5_busy_after", busy_a, 0);
        check("a5_done_once", done_cnt[0], 5);

        // three words at H=2: frame starts 1 + 19*2 + 1 = 40 apart
        div_a = 16'd2;
        k = cyc;
        for (int i = 0; i < 3; i++) push_a(three_words[i]);
        check("three_level_after_push", level_a, 2);
        wait_frames(0, 8, 400, "three_frames");
        check("three_start", f_start[0][5], k + 2);
        check("three_spacing_0", f_start[0][6] - f_start[0][5], 40);
        check("three_spacing_1", f_start[0][7] - f_start[0][6], 40);
        for (int i = 0; i < 3; i++)
            check_frame(0, 5 + i, three_words[i][7:0], three_words[i][8], 37);
        check("three_level_end", level_a, 0);

        // flush mid-frame: frame in flight completes, queued word and same-cycle push dropped
        div_a = 16'd4;
        push_a(9'h15A);
        push_a(9'h0C3);
        repeat (10) step();
        check("flush_level_before", level_a, 1);
        flush_a = 1'b1;
        wr_en_a = 1'b1;
        {wr_dc_a, wr_data_a} = 9'h177;
        step();
        flush_a = 1'b0;
        wr_en_a = 1'b0;
        check("flush_level_after", level_a, 0);
        wait_frames(0, 9, 300, "flush_frame");
        check_frame(0, 8, 8'h5A, 1'b1, 73);
        repeat (100) step();
        check("flush_no_more_frames", nfr[0], 9);
        check("flush_busy_after", busy_a, 0);
        check("mode0_mosi_only_on_fall", mosi_bad[0], 0);

        // mode 3 instance, div_factor = 0 acts as H = 1
        k = cyc;
        wr_en_b = 1'b1;
        {wr_dc_b, wr_data_b} = 9'h03C;
        step();
        wr_en_b = 1'b0;
        wait_frames(1, 1, 100, "m3_frame");
        check("m3_start", f_start[1][0], k + 2);
        check_frame(1, 0, 8'h3C, 1'b0, 19);
        check("m3_mosi_only_on_fall", mosi_bad[1], 0);
        check("m3_sclk_idle_high", sclk_b, 1);

        // Reset asserted mid-SHIFT aborts the frame and restarts INIT
        push_a(9'h1FF);
        push_a(9'h012);
        n = 0;
        while (!sclk_a && n < 50) begin
            step();
            n++;
        end
        check("midrst_in_shift", sclk_a, 1);
        check("midrst_level_before", level_a, 1);
        Reset = 1'b0;
        #1;
        check("midrst_sce", sce_a, 1);
        check("midrst_rst", rst_a, 0);
        check("midrst_level", level_a, 0);
        check("midrst_sclk", sclk_a, 0);
        check("midrst_dc", dc_a, 0);
        check("midrst_ready", ready_a, 0);
        check("midrst_busy", busy_a, 0);
        step();
        step();
        Reset = 1'b1;
        measure_init("reinit");
        check("midrst_frame_not_counted", nfr[0], 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
